// File: rtl/pll_reset_sequencer.sv
// Purpose: sequences PLL reset, waits for lock with timeout/retry, settles, then releases system reset.
// Latency: lock to FSM is 2 synchronizer cycles; all outputs are Moore-decoded from registered state.
// Backpressure: none; relock_req_i is a single-cycle pulse acted on only in RUN and FAULT.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 7090,
    parameter int SETTLE_CYCLES   = 256,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       clkin_i,
    input  logic       reset_i,
    input  logic       lock_i,
    input  logic       relock_req_i,
    output logic       pll_reset_o,
    output logic       sys_reset_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [7:0] retry_cnt_o,
    output logic [7:0] lock_loss_cnt_o
);

    // The shared counter must reach the largest terminal value among the three phases.
    localparam int MAX_HS  = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CNT = (MAX_HS > LOCK_TIMEOUT) ? MAX_HS : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_cnt_q, retry_cnt_d;
    logic [7:0]       lock_loss_cnt_q, lock_loss_cnt_d;
    logic             lock_meta_q;
    logic             lock_s_q;
    logic [7:0]       retry_inc;

    assign retry_inc = retry_cnt_q + 8'd1;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clkin.
    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State, shared phase counter and statistics registers.
    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            state_q         <= ST_HOLD;
            cnt_q           <= '0;
            retry_cnt_q     <= 8'd0;
            lock_loss_cnt_q <= 8'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_cnt_q     <= retry_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    // Next-state logic; every phase change restarts the shared counter at zero.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        retry_cnt_d     = retry_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_cnt_d = retry_inc;
                    state_d     = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                // A dropout while settling is a glitch, not a timeout: retry_cnt is kept.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    retry_cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // Lock loss wins over a coincident relock request and is counted.
                if (!lock_s_q) begin
                    state_d = ST_HOLD;
                    if (lock_loss_cnt_q != 8'hFF) begin
                        lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                    end
                end else if (relock_req_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
                if (relock_req_i) begin
                    state_d     = ST_HOLD;
                    retry_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        pll_reset_o = (state_q == ST_HOLD) || (state_q == ST_FAULT);
        sys_reset_o = (state_q != ST_RUN);
        ready_o     = (state_q == ST_RUN);
        fault_o     = (state_q == ST_FAULT);
    end

    assign retry_cnt_o     = retry_cnt_q;
    assign lock_loss_cnt_o = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer with default parameters.
// Directed scenarios on an absolute edge schedule, then a randomized soak.
// Every cycle is compared against a time-in-phase reference model.
module tb_pll_reset_sequencer;

    localparam int RST_HOLD_CYCLES = 16;
    localparam int LOCK_TIMEOUT    = 7090;
    localparam int SETTLE_CYCLES   = 256;
    localparam int MAX_RETRIES     = 3;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset, sys_reset, ready, fault;
    logic [7:0] retry_cnt, lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES(RST_HOLD_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) dut (
        .clkin_i        (clkin),
        .reset_i        (reset),
        .lock_i         (lock),
        .relock_req_i   (relock_req),
        .pll_reset_o    (pll_reset),
        .sys_reset_o    (sys_reset),
        .ready_o        (ready),
        .fault_o        (fault),
        .retry_cnt_o    (retry_cnt),
        .lock_loss_cnt_o(lock_loss_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp);
        end
    endtask

    // Reference model: phase plus the edge on which it was entered; lock as seen
    // by the sequencer is the lock input sampled two edges earlier.
    localparam int P_HOLD = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAULT = 4;
    int m_edge = 0, m_entered = 0, m_phase = P_HOLD, m_retries = 0, m_losses = 0, m_el;
    bit m_s1 = 0, m_s2 = 0, m_ls;

    function automatic void enter(input int p);
        m_phase   = p;
        m_entered = m_edge;
    endfunction

    always @(posedge clkin) begin
        m_edge++;
        if (reset) begin
            enter(P_HOLD);
            m_retries = 0;
            m_losses  = 0;
            m_s1      = 0;
            m_s2      = 0;
        end else begin
            m_ls = m_s2;
            m_s2 = m_s1;
            m_s1 = lock;
            m_el = m_edge - m_entered;
            case (m_phase)
                P_HOLD: if (m_el == RST_HOLD_CYCLES) enter(P_WAIT);
                P_WAIT: begin
                    if (m_ls) enter(P_SETTLE);
                    else if (m_el == LOCK_TIMEOUT) begin
                        m_retries++;
                        enter((m_retries == MAX_RETRIES) ? P_FAULT : P_HOLD);
                    end
                end
                P_SETTLE: begin
                    if (!m_ls) enter(P_WAIT);
                    else if (m_el == SETTLE_CYCLES) begin
                        m_retries = 0;
                        enter(P_RUN);
                    end
                end
                P_RUN: begin
                    if (!m_ls) begin
                        if (m_losses < 255) m_losses++;
                        enter(P_HOLD);
                    end else if (relock_req) enter(P_HOLD);
                end
                default: begin
                    if (relock_req) begin
                        m_retries = 0;
                        enter(P_HOLD);
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clkin) begin
        if (m_edge > 0) begin
            chk("m_pll_reset", pll_reset, (m_phase == P_HOLD || m_phase == P_FAULT) ? 1 : 0);
            chk("m_sys_reset", sys_reset, (m_phase != P_RUN) ? 1 : 0);
            chk("m_ready", ready, (m_phase == P_RUN) ? 1 : 0);
            chk("m_fault", fault, (m_phase == P_FAULT) ? 1 : 0);
            chk("m_retry_cnt", retry_cnt, m_retries);
            chk("m_lock_loss_cnt", lock_loss_cnt, m_losses);
        end
    end

    // Advance to just after edge k (inputs may then be driven for edge k+1).
    task automatic go_to(input int k);
        while (e < k) begin
            @(negedge clkin);
            e++;
        end
    endtask

    task automatic pulse_relock(input int k);
        go_to(k - 1);
        relock_req = 1'b1;
        go_to(k);
        relock_req = 1'b0;
    endtask

    int hold_left = 0;

    initial begin
        repeat (3) @(negedge clkin);
        chk("reset_pll_reset", pll_reset, 1);
        chk("reset_sys_reset", sys_reset, 1);
        chk("reset_ready", ready, 0);
        chk("reset_fault", fault, 0);
        reset = 1'b0;
        e = 0;

        // Nominal bring-up: lock rises before edge 20.
        go_to(15);  chk("bringup_pll_hi_e15", pll_reset, 1);
        go_to(16);  chk("bringup_pll_lo_e16", pll_reset, 0);
        go_to(19);  lock = 1'b1;
        go_to(277); chk("bringup_ready_e277", ready, 0);
        go_to(278); chk("bringup_ready_e278", ready, 1);
        chk("bringup_sys_reset_e278", sys_reset, 0);
        chk("bringup_retry_e278", retry_cnt, 0);

        // Lock loss in RUN: lock falls before edge 301, HOLD on edge 303.
        go_to(300); lock = 1'b0;
        go_to(302); chk("loss_ready_e302", ready, 1);
        go_to(303); chk("loss_pll_e303", pll_reset, 1);
        chk("loss_sys_e303", sys_reset, 1);
        chk("loss_cnt_e303", lock_loss_cnt, 1);
        lock = 1'b1;
        go_to(575); chk("loss_rerun_ready_e575", ready, 0);
        go_to(576); chk("loss_rerun_ready_e576", ready, 1);

        // Lock loss coincident with relock_req at the sequencer on edge 603.
        go_to(600); lock = 1'b0;
        pulse_relock(603);
        chk("simul_pll_e603", pll_reset, 1);
        chk("simul_loss_e603", lock_loss_cnt, 2);
        lock = 1'b1;
        go_to(876); chk("simul_rerun_ready_e876", ready, 1);

        // relock_req alone in RUN: HOLD on edge 901, loss count kept.
        pulse_relock(901);
        chk("relock_pll_e901", pll_reset, 1);
        chk("relock_ready_e901", ready, 0);
        chk("relock_loss_e901", lock_loss_cnt, 2);

        // SETTLE entered at 918; 3-cycle dropout at settle count 100.
        go_to(1018); lock = 1'b0;
        go_to(1021); lock = 1'b1;
        go_to(1022); chk("glitch_retry_e1022", retry_cnt, 0);
        go_to(1174); chk("glitch_not_early_e1174", ready, 0);
        go_to(1279); chk("glitch_ready_e1279", ready, 0);
        go_to(1280); chk("glitch_ready_e1280", ready, 1);

        // Timeouts with lock held low; relock pulses in WAIT_LOCK and HOLD are ignored.
        go_to(1300); lock = 1'b0;
        go_to(1303); chk("to_loss_e1303", lock_loss_cnt, 3);
        pulse_relock(1400);
        pulse_relock(5000);
        go_to(8408); chk("to_retry_e8408", retry_cnt, 0);
        chk("to_pll_e8408", pll_reset, 0);
        go_to(8409); chk("to_retry_e8409", retry_cnt, 1);
        chk("to_pll_e8409", pll_reset, 1);
        pulse_relock(8415);
        pulse_relock(9000);
        go_to(15515); chk("to_retry_e15515", retry_cnt, 2);
        pulse_relock(20000);
        go_to(22620); chk("to_fault_e22620", fault, 0);
        go_to(22621); chk("to_fault_e22621", fault, 1);
        chk("to_pll_e22621", pll_reset, 1);
        chk("to_retry_e22621", retry_cnt, 3);
        pulse_relock(22701);
        chk("fault_exit_fault", fault, 0);
        chk("fault_exit_retry", retry_cnt, 0);
        chk("fault_exit_pll", pll_reset, 1);

        // Reset in the middle of SETTLE (entered on edge 22723).
        go_to(22720); lock = 1'b1;
        go_to(22800); chk("mid_settle_pll", pll_reset, 0);
        reset = 1'b1;
        go_to(22801);
        chk("rst_pll", pll_reset, 1);
        chk("rst_sys", sys_reset, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_loss", lock_loss_cnt, 0);
        go_to(22803); reset = 1'b0;

        // Randomized soak: long lock-high spans, short dropouts, sparse relock and reset.
        for (int i = 0; i < 6000; i++) begin
            go_to(e + 1);
            if (hold_left == 0) begin
                lock = ~lock;
                hold_left = lock ? $urandom_range(400, 20) : $urandom_range(30, 1);
            end else begin
                hold_left--;
            end
            relock_req = ($urandom_range(149, 0) == 0);
            reset      = ($urandom_range(1999, 0) == 0);
        end
        relock_req = 1'b0;
        reset      = 1'b0;
        go_to(e + 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
